// File: rtl/sram_stream_reader_pkg.sv
// Shared types and default sizes for the SRAM stream reader.
package sram_stream_reader_pkg;

    localparam int unsigned NUM_WORDS_DEFAULT  = 131072;
    localparam int unsigned WORD_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StLast = 2'd2
    } state_e;

endpackage

// File: rtl/sram_stream_reader.sv
// Streams a burst of SRAM words out as two-word beats, reading both SRAM ports
// each cycle, with ready/valid backpressure, abort and a completion pulse.
module sram_stream_reader
    import sram_stream_reader_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = NUM_WORDS_DEFAULT,
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEFAULT,
    localparam int unsigned AW        = $clog2(NUM_WORDS)
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    start,
    input  logic [AW-1:0]           base_addr,
    input  logic [AW:0]             length,
    input  logic                    abort,
    output logic [AW-1:0]           read_addr_1,
    output logic [AW-1:0]           read_addr_2,
    input  logic [WORD_WIDTH-1:0]   read_data_1,
    input  logic [WORD_WIDTH-1:0]   read_data_2,
    output logic [2*WORD_WIDTH-1:0] out_data,
    output logic [1:0]              out_keep,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam logic [AW:0] NumWordsW = (AW + 1)'(NUM_WORDS);
    localparam logic [AW:0] One       = (AW + 1)'(1);
    localparam logic [AW:0] Two       = (AW + 1)'(2);

    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input logic [AW:0] inc);
        logic [AW:0] s;
        s = {1'b0, a} + inc;
        if (s >= NumWordsW) begin
            s = s - NumWordsW;
        end
        return s[AW-1:0];
    endfunction

    state_e                  state_q, state_d;
    logic [AW-1:0]           ptr_q, ptr_d;
    logic [AW:0]             rem_q, rem_d;
    logic [2*WORD_WIDTH-1:0] data_q, data_d;
    logic [1:0]              keep_q, keep_d;
    logic                    last_q, last_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;

    logic [AW-1:0] cur_ptr;
    logic [AW:0]   cur_rem;
    logic [AW:0]   step;
    logic          load;

    // In IDLE the read ports look at base_addr so the first beat loads on the start edge.
    assign cur_ptr = (state_q == StIdle) ? base_addr : ptr_q;
    assign cur_rem = (state_q == StIdle) ? length : rem_q;
    assign step    = (cur_rem >= Two) ? Two : cur_rem;

    always_comb begin
        load = 1'b0;
        if (state_q == StIdle) begin
            load = start && (length != '0);
        end else if (state_q == StRun) begin
            load = !valid_q || out_ready;
        end
    end

    assign read_addr_1 = cur_ptr;
    assign read_addr_2 = wrap_add(cur_ptr, One);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = StIdle;
            keep_d  = 2'b00;
            last_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && (length == '0)) begin
                        done_d = 1'b1;
                    end
                end
                StLast: begin
                    if (out_ready) begin
                        state_d = StIdle;
                        keep_d  = 2'b00;
                        last_d  = 1'b0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
            if (load) begin
                data_d  = {read_data_2, read_data_1};
                keep_d  = (cur_rem >= Two) ? 2'b11 : 2'b01;
                last_d  = (cur_rem <= Two);
                valid_d = 1'b1;
                ptr_d   = wrap_add(cur_ptr, Two);
                rem_d   = cur_rem - step;
                state_d = (cur_rem <= Two) ? StLast : StRun;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            keep_q  <= 2'b00;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Randomized and directed bench for sram_stream_reader against a burst-level
// reference model of a 16 x 8-bit SRAM holding mem[i] = i + 8'h10.
module tb_sram_stream_reader;

    localparam int unsigned NW = 16;
    localparam int unsigned WW = 8;
    localparam int unsigned AW = 4;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        last;
    } beat_t;

    logic          clk;
    logic          rst_l;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          abort;
    logic [AW-1:0] read_addr_1;
    logic [AW-1:0] read_addr_2;
    logic [WW-1:0] read_data_1;
    logic [WW-1:0] read_data_2;
    logic [15:0]   out_data;
    logic [1:0]    out_keep;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    logic [WW-1:0] mem [NW];

    int n_tests;
    int n_fail;

    sram_stream_reader #(
        .NUM_WORDS (NW),
        .WORD_WIDTH(WW)
    ) u_dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .abort      (abort),
        .read_addr_1(read_addr_1),
        .read_addr_2(read_addr_2),
        .read_data_1(read_data_1),
        .read_data_2(read_data_2),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    assign read_data_1 = mem[read_addr_1];
    assign read_data_2 = mem[read_addr_2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: beat k covers words base+2k and base+2k+1 (mod 16).
    task automatic build_expected(input int base, input int len, output beat_t q[$]);
        int nbeats;
        beat_t b;
        q = {};
        nbeats = (len + 1) / 2;
        for (int k = 0; k < nbeats; k++) begin
            b.data = {mem[(base + 2 * k + 1) % NW], mem[(base + 2 * k) % NW]};
            b.keep = (len - 2 * k >= 2) ? 2'b11 : 2'b01;
            b.last = (k == nbeats - 1);
            q.push_back(b);
        end
    endtask

    task automatic check_beat(input string tag, input beat_t e);
        logic [15:0] mask;
        mask = (e.keep == 2'b11) ? 16'hFFFF : 16'h00FF;
        check({tag, "_data"}, 32'(out_data & mask), 32'(e.data & mask));
        check({tag, "_keep"}, 32'(out_keep), 32'(e.keep));
        check({tag, "_last"}, 32'(out_last), 32'(e.last));
    endtask

    // Called at a negedge; returns at a negedge one cycle after done.
    task automatic run_burst(input int base, input int len, input int stall_pct);
        beat_t q[$];
        int    cyc;
        bit    rdy;
        build_expected(base, len, q);
        start     = 1'b1;
        base_addr = AW'(base);
        length    = (AW + 1)'(len);
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (len == 0) begin
            check("len0_done", 32'(done), 32'd1);
            check("len0_busy", 32'(busy), 32'd0);
            check("len0_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
            check("len0_done_clr", 32'(done), 32'd0);
            return;
        end
        check("latency", 32'(out_valid), 32'd1);
        cyc = 0;
        while (q.size() > 0 && cyc < 200) begin
            check("raddr2", 32'(read_addr_2), 32'((read_addr_1 + 1) % NW));
            check("busy", 32'(busy), 32'd1);
            if (stall_pct == 0) check("nobubble", 32'(out_valid), 32'd1);
            if (out_valid) check_beat("beat", q[0]);
            rdy = ($urandom_range(99) >= stall_pct);
            out_ready = rdy;
            if (out_valid && rdy) void'(q.pop_front());
            @(negedge clk);
            cyc++;
        end
        check("timeout", 32'(q.size()), 32'd0);
        out_ready = 1'b0;
        check("done", 32'(done), 32'd1);
        check("end_valid", 32'(out_valid), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_clr", 32'(done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        for (int i = 0; i < NW; i++) mem[i] = 8'(i + 8'h10);
        rst_l     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_keep", 32'(out_keep), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_l = 1'b1;
        @(negedge clk);

        run_burst(2, 6, 0);
        run_burst(14, 5, 0);
        run_burst(0, 0, 0);

        // Three stalled cycles on the first beat, then drain.
        start = 1'b1; base_addr = 4'd0; length = 5'd4; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'h1110);
            check("stall_last", 32'(out_last), 32'd0);
            @(negedge clk);
        end
        check("stall_hold", 32'(out_data), 32'h1110);
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_b2_data", 32'(out_data), 32'h1312);
        check("stall_b2_last", 32'(out_last), 32'd1);
        @(negedge clk);
        check("stall_done", 32'(done), 32'd1);
        check("stall_end_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        @(negedge clk);

        // Abort while the second beat is pending.
        start = 1'b1; base_addr = 4'd4; length = 5'd6; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_b1", 32'(out_data), 32'h1514);
        @(negedge clk);
        check("abort_b2", 32'(out_data), 32'h1716);
        abort = 1'b1; out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_keep", 32'(out_keep), 32'd0);
        @(negedge clk);
        check("abort_done2", 32'(done), 32'd0);
        run_burst(4, 6, 0);

        // Asynchronous reset in the middle of a burst.
        start = 1'b1; base_addr = 4'd6; length = 5'd8; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_l = 1'b0;
        #1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_data", 32'(out_data), 32'd0);
        check("mrst_keep", 32'(out_keep), 32'd0);
        check("mrst_last", 32'(out_last), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        out_ready = 1'b0;
        run_burst(0, 2, 0);

        run_burst(3, 16, 0);
        for (int t = 0; t < 40; t++) begin
            run_burst(int'($urandom_range(NW - 1)), int'($urandom_range(NW)),
                      int'($urandom_range(60)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
